// File: rtl/mu_cell_scheduler.sv
// mu_cell_scheduler: sequences one shared motion_update unit over NUM_CELLS cell caches per MD phase
module mu_cell_scheduler #(
  parameter int NUM_CELLS     = 8,
  parameter int CELL_ID_WIDTH = 3,
  parameter int DRAIN_CYCLES  = 16,
  parameter int START_TIMEOUT = 64,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_phase_start,
  input  logic                     i_mu_rd_en,
  input  logic                     i_mu_data_valid,
  output logic                     o_mu_start,
  output logic [CELL_ID_WIDTH-1:0] o_cell_sel,
  output logic                     o_busy,
  output logic                     o_phase_done,
  output logic [CNT_WIDTH-1:0]     o_iter_cnt,
  output logic [CNT_WIDTH-1:0]     o_particles_updated,
  output logic                     o_timeout_err
);
  typedef enum logic [2:0] {IDLE, START, WAIT_RISE, WAIT_FALL, DRAIN, DONE} state_t;
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int QW = $clog2(DRAIN_CYCLES + 1);
  state_t        state_q;
  logic [TW-1:0] tmo_q;
  logic [QW-1:0] quiet_q;
  logic          last_cell;
  assign last_cell = o_cell_sel == CELL_ID_WIDTH'(NUM_CELLS - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q             <= IDLE;
      tmo_q               <= '0;
      quiet_q             <= '0;
      o_mu_start          <= 1'b0;
      o_cell_sel          <= '0;
      o_busy              <= 1'b0;
      o_phase_done        <= 1'b0;
      o_iter_cnt          <= '0;
      o_particles_updated <= '0;
      o_timeout_err       <= 1'b0;
    end else begin
      o_mu_start   <= 1'b0;
      o_phase_done <= 1'b0;
      if (o_busy && i_mu_data_valid && !(&o_particles_updated))
        o_particles_updated <= o_particles_updated + 1'b1;
      case (state_q)
        IDLE: if (i_phase_start) begin
          o_cell_sel          <= '0;
          o_busy              <= 1'b1;
          o_particles_updated <= '0;
          o_mu_start          <= 1'b1;
          state_q             <= START;
        end
        START: begin
          tmo_q   <= '0;
          state_q <= WAIT_RISE;
        end
        // a rise on the expiry cycle is checked first, so it wins over the timeout
        WAIT_RISE: if (i_mu_rd_en) state_q <= WAIT_FALL;
          else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
            o_timeout_err <= 1'b1;
            quiet_q       <= '0;
            state_q       <= DRAIN;
          end else tmo_q <= tmo_q + 1'b1;
        WAIT_FALL: if (!i_mu_rd_en) begin
          quiet_q <= '0;
          state_q <= DRAIN;
        end
        DRAIN: if (i_mu_data_valid) quiet_q <= '0;
          else if (quiet_q == QW'(DRAIN_CYCLES - 1)) begin
            if (last_cell) begin
              o_phase_done <= 1'b1;
              state_q      <= DONE;
            end else begin
              o_cell_sel <= o_cell_sel + 1'b1;
              o_mu_start <= 1'b1;
              state_q    <= START;
            end
          end else quiet_q <= quiet_q + 1'b1;
        DONE: begin
          o_busy     <= 1'b0;
          o_iter_cnt <= o_iter_cnt + 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mu_cell_scheduler.sv
// tb_mu_cell_scheduler: randomized MU responder with a cycle reference model and literal phase checks
module tb_mu_cell_scheduler;
  localparam int N = 4, CW = 3, D = 16, TO = 64, W = 4;
  localparam int M_OFF = 0, M_ARM = 1, M_RISE = 2, M_SWEEP = 3, M_DRAIN = 4, M_FIN = 5;
  logic clk = 0, rst_n = 0, i_phase_start = 0, i_mu_rd_en = 0, i_mu_data_valid = 0;
  logic o_mu_start, o_busy, o_phase_done, o_timeout_err;
  logic [CW-1:0] o_cell_sel;
  logic [W-1:0] o_iter_cnt, o_particles_updated;
  mu_cell_scheduler #(.NUM_CELLS(N), .CELL_ID_WIDTH(CW), .DRAIN_CYCLES(D), .START_TIMEOUT(TO),
    .CNT_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_phase_start(i_phase_start), .i_mu_rd_en(i_mu_rd_en),
    .i_mu_data_valid(i_mu_data_valid), .o_mu_start(o_mu_start), .o_cell_sel(o_cell_sel),
    .o_busy(o_busy), .o_phase_done(o_phase_done), .o_iter_cnt(o_iter_cnt),
    .o_particles_updated(o_particles_updated), .o_timeout_err(o_timeout_err));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, starts = 0, dones = 0;
  int cells[$];
  bit rd_map[int], vld_map[int];
  bit rnd = 0;
  int never_cell = -1, cfg_p = 3, cfg_lat = 2;
  int sd, sn, sp, sl, sg;
  bit snev;
  int mode = M_OFF, t_start = 0, qfrom = 0, m_cell = 0, m_iter = 0, m_parts = 0;
  bit m_busy = 0, m_start = 0, m_done = 0, m_err = 0;
  // reference: timestamps of the start pulse and of the start of the current quiet run
  always @(posedge clk) begin
    if (!rst_n) begin
      mode = M_OFF; m_cell = 0; m_iter = 0; m_parts = 0;
      m_busy = 0; m_start = 0; m_done = 0; m_err = 0;
    end else begin
      m_start = 0; m_done = 0;
      if (m_busy && i_mu_data_valid && m_parts < 2**W - 1) m_parts++;
      case (mode)
        M_OFF: if (i_phase_start) begin
          m_cell = 0; m_busy = 1; m_parts = 0; m_start = 1; mode = M_ARM;
        end
        M_ARM: begin t_start = cyc; mode = M_RISE; end
        M_RISE: if (i_mu_rd_en) mode = M_SWEEP;
          else if (cyc - t_start >= TO) begin m_err = 1; qfrom = cyc + 1; mode = M_DRAIN; end
        M_SWEEP: if (!i_mu_rd_en) begin qfrom = cyc + 1; mode = M_DRAIN; end
        M_DRAIN: if (i_mu_data_valid) qfrom = cyc + 1;
          else if (cyc - qfrom + 1 >= D) begin
            if (m_cell == N - 1) begin m_done = 1; mode = M_FIN; end
            else begin m_cell++; m_start = 1; mode = M_ARM; end
          end
        M_FIN: begin m_busy = 0; m_iter = (m_iter + 1) % (2**W); mode = M_OFF; end
        default: mode = M_OFF;
      endcase
    end
    cyc++;
  end
  always @(negedge clk) begin
    checks++;
    if ({o_mu_start, o_cell_sel, o_busy, o_phase_done, o_iter_cnt, o_particles_updated, o_timeout_err} !==
        {m_start, CW'(m_cell), m_busy, m_done, W'(m_iter), W'(m_parts), m_err}) begin
      errors++;
      $display("FAIL cycle %0d got start=%b cell=%0d busy=%b done=%b iter=%0d parts=%0d err=%b expected start=%b cell=%0d busy=%b done=%b iter=%0d parts=%0d err=%b",
        cyc, o_mu_start, o_cell_sel, o_busy, o_phase_done, o_iter_cnt, o_particles_updated, o_timeout_err,
        m_start, m_cell, m_busy, m_done, m_iter, m_parts, m_err);
    end
    if (o_phase_done) dones++;
    if (o_mu_start) begin
      starts++;
      cells.push_back(int'(o_cell_sel));
      sd = 2; sn = 3; sp = cfg_p; sl = cfg_lat; sg = 1;
      snev = int'(o_cell_sel) == never_cell;
      if (rnd) begin
        snev = $urandom_range(9) == 0;
        sd = ($urandom_range(4) == 0) ? int'($urandom_range(66, 62)) : int'($urandom_range(4, 1));
        sn = int'($urandom_range(4, 1));
        sp = int'($urandom_range(5, 0));
        sl = int'($urandom_range(12, 0));
        sg = int'($urandom_range(3, 1));
      end
      if (!snev) begin
        for (int j = 0; j < sn; j++) rd_map[cyc + sd + j] = 1;
        for (int k = 0; k < sp; k++) vld_map[cyc + sd + sn - 1 + sl + k * sg] = 1;
      end
    end
    i_mu_rd_en = rd_map.exists(cyc) != 0;
    i_mu_data_valid = vld_map.exists(cyc) != 0;
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run_phase(input bit noise, input bit dup);
    int b;
    bit pulsed;
    starts = 0; dones = 0; cells.delete();
    @(negedge clk); i_phase_start = 1;
    @(negedge clk); i_phase_start = 0;
    b = 0; pulsed = 0;
    while (!o_phase_done && b < 4000) begin
      @(negedge clk); b++;
      i_phase_start = noise && m_busy && ($urandom_range(19) == 0);
      if (dup && !pulsed && rd_map.exists(cyc - 1) && rd_map.exists(cyc)) begin
        i_phase_start = 1; pulsed = 1;
      end
    end
    i_phase_start = 0;
    if (b >= 4000) begin
      checks++; errors++;
      $display("FAIL phase_wait no o_phase_done within 4000 cycles");
    end
    @(negedge clk);
  endtask
  initial begin
    int b;
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_iter", int'(o_iter_cnt), 0);
    chk("reset_parts", int'(o_particles_updated), 0);
    chk("reset_err", int'(o_timeout_err), 0);
    run_phase(0, 0);
    chk("t1_starts", starts, 4);
    chk("t1_cell_order", cells.size() == 4 ? cells[0]*1000 + cells[1]*100 + cells[2]*10 + cells[3] : -1, 123);
    chk("t1_parts", int'(o_particles_updated), 12);
    chk("t1_iter", int'(o_iter_cnt), 1);
    chk("t1_dones", dones, 1);
    chk("t1_busy", int'(o_busy), 0);
    chk("t1_err", int'(o_timeout_err), 0);
    never_cell = 2;
    run_phase(0, 0);
    chk("t2_err", int'(o_timeout_err), 1);
    chk("t2_starts", starts, 4);
    chk("t2_dones", dones, 1);
    chk("t2_parts", int'(o_particles_updated), 9);
    never_cell = -1; cfg_lat = 10;
    run_phase(0, 0);
    chk("t3_parts_late", int'(o_particles_updated), 12);
    chk("t3_iter", int'(o_iter_cnt), 3);
    cfg_lat = 2;
    run_phase(0, 1);
    chk("t4_dones", dones, 1);
    chk("t4_iter", int'(o_iter_cnt), 4);
    cfg_p = 5;
    run_phase(0, 0);
    chk("sat_parts", int'(o_particles_updated), 15);
    cfg_p = 3;
    @(negedge clk); i_phase_start = 1;
    @(negedge clk); i_phase_start = 0;
    b = 0;
    while (!(m_cell == 1 && mode == M_DRAIN) && b < 2000) begin @(negedge clk); b++; end
    if (b >= 2000) begin checks++; errors++; $display("FAIL t5_wait never reached drain of cell 1"); end
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk); rst_n = 1;
    chk("t5_busy", int'(o_busy), 0);
    chk("t5_cell", int'(o_cell_sel), 0);
    chk("t5_iter", int'(o_iter_cnt), 0);
    chk("t5_err", int'(o_timeout_err), 0);
    repeat (5) @(negedge clk);
    chk("t5_no_done", int'(o_phase_done), 0);
    run_phase(0, 0);
    chk("t5_restart_cell0", cells.size() > 0 ? cells[0] : -1, 0);
    chk("t5_iter_after", int'(o_iter_cnt), 1);
    rnd = 1;
    for (int i = 0; i < 14; i++) run_phase(1, 0);
    chk("wrap_pre", int'(o_iter_cnt), 15);
    run_phase(1, 0);
    chk("wrap_zero", int'(o_iter_cnt), 0);
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
